// File: rtl/inst_sram_fetch_bridge_pkg.sv
// ============================================================================
// Module  : inst_sram_fetch_bridge_pkg
// Brief   : Shared fetch-bridge types: FSM state encoding, kseg constants.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package inst_sram_fetch_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DISC = 2'd3
    } fetch_state_e;

    localparam logic [2:0]  C_KSEG0_TOP = 3'b100;
    localparam logic [2:0]  C_KSEG1_TOP = 3'b101;
    localparam logic [31:0] C_NOP_INST  = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/inst_sram_fetch_bridge_addr_map.sv
// ============================================================================
// Module  : inst_addr_map
// Brief   : Combinational virtual->physical mapping (kseg0/kseg1 fold to 0).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module inst_addr_map
    import inst_sram_fetch_bridge_pkg::*;
#(
    parameter bit ADDR_MAP_EN = 1'b1
) (
    input  logic [31:0] i_vaddr,
    output logic [31:0] o_paddr
);

    generate
        if (ADDR_MAP_EN) begin : g_map
            logic w_kseg01;
            assign w_kseg01 = (i_vaddr[31:29] == C_KSEG0_TOP) ||
                              (i_vaddr[31:29] == C_KSEG1_TOP);
            assign o_paddr  = w_kseg01 ? {3'b000, i_vaddr[28:0]} : i_vaddr;
        end else begin : g_nomap
            assign o_paddr = i_vaddr;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/inst_sram_fetch_bridge.sv
// ============================================================================
// Module  : inst_sram_fetch_bridge
// Brief   : Fetch PC -> SRAM-like instruction bus, with stall and stale drop.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module inst_sram_fetch_bridge
    import inst_sram_fetch_bridge_pkg::*;
#(
    parameter bit          ADDR_MAP_EN = 1'b1,
    parameter logic [31:0] NOP_INST    = C_NOP_INST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        pc_valid,
    input  logic        hold,
    input  logic        flush,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok,
    output logic [31:0] if_inst,
    output logic        if_inst_valid,
    output logic        fetch_stall,
    output logic        adel,
    output logic [31:0] badvaddr
);

    fetch_state_e r_state;
    logic [31:0]  r_fetched_pc;
    logic         r_disc_pend;
    logic [31:0]  w_paddr;
    logic         w_need;
    logic         w_unaligned;

    inst_addr_map #(
        .ADDR_MAP_EN (ADDR_MAP_EN)
    ) u_addr_map (
        .i_vaddr (pc),
        .o_paddr (w_paddr)
    );

    assign w_unaligned = (pc[1:0] != 2'b00);
    assign w_need      = pc_valid & ~(if_inst_valid & (r_fetched_pc == pc));

    // Stall drops in the cycle the answer is certain to be latched at the next edge.
    assign fetch_stall = w_need
                       & ~((r_state == ST_WAIT) & inst_data_ok & ~flush)
                       & ~((r_state == ST_IDLE) & w_unaligned & ~hold);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_fetched_pc  <= 32'h0;
            r_disc_pend   <= 1'b0;
            inst_req      <= 1'b0;
            inst_addr     <= 32'h0;
            if_inst       <= NOP_INST;
            if_inst_valid <= 1'b0;
            adel          <= 1'b0;
            badvaddr      <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_need && !hold && !flush) begin
                        r_fetched_pc <= pc;
                        if (w_unaligned) begin
                            adel          <= 1'b1;
                            badvaddr      <= pc;
                            if_inst       <= NOP_INST;
                            if_inst_valid <= 1'b1;
                        end else begin
                            // Old word no longer matches fetched_pc, so it must not satisfy need.
                            if_inst_valid <= 1'b0;
                            inst_addr     <= w_paddr;
                            inst_req      <= 1'b1;
                            r_state       <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (inst_addr_ok) begin
                        inst_req <= 1'b0;
                        r_state  <= (flush || r_disc_pend) ? ST_DISC : ST_WAIT;
                    end else if (flush) begin
                        r_disc_pend <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (inst_data_ok) begin
                        if (!flush) begin
                            if_inst       <= inst_rdata;
                            if_inst_valid <= 1'b1;
                            adel          <= 1'b0;
                        end
                        r_state <= ST_IDLE;
                    end else if (flush) begin
                        r_state <= ST_DISC;
                    end
                end
                ST_DISC: begin
                    if (inst_data_ok) begin
                        r_disc_pend <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (flush) begin
                if_inst_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
